// File: rtl/dmem_lsu.sv
// Byte-addressable little-endian data memory with a valid/ready request port and a registered
// response; word-crossing accesses are optionally split into two internal beats.
module dmem_lsu #(
  parameter int unsigned ADDR_W         = 11,
  parameter bit          INIT_ON_RESET  = 1'b1,
  parameter logic [31:0] INIT_VALUE     = 32'h0000_0000,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int unsigned WORD_W      = ADDR_W - 2;
  localparam int unsigned DEPTH_WORDS = 1 << WORD_W;

  localparam logic [5:0] OpLb  = 6'b010011;
  localparam logic [5:0] OpLh  = 6'b010100;
  localparam logic [5:0] OpLw  = 6'b010101;
  localparam logic [5:0] OpLbu = 6'b010110;
  localparam logic [5:0] OpLhu = 6'b010111;
  localparam logic [5:0] OpSb  = 6'b011000;
  localparam logic [5:0] OpSh  = 6'b011001;
  localparam logic [5:0] OpSw  = 6'b011010;

  typedef enum logic [1:0] {StInit, StIdle, StSplit} state_e;

  // Access size in bytes; 0 marks an illegal op.
  function automatic logic [2:0] op_size(input logic [5:0] o);
    case (o)
      OpLb, OpLbu, OpSb: return 3'd1;
      OpLh, OpLhu, OpSh: return 3'd2;
      OpLw, OpSw:        return 3'd4;
      default:           return 3'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] o);
    return (o == OpSb) || (o == OpSh) || (o == OpSw);
  endfunction

  // Stores fall through to zero so the response carries rdata=0.
  function automatic logic [31:0] load_fmt(input logic [5:0] o, input logic [31:0] b);
    case (o)
      OpLb:    return {{24{b[7]}}, b[7:0]};
      OpLbu:   return {24'h0, b[7:0]};
      OpLh:    return {{16{b[15]}}, b[15:0]};
      OpLhu:   return {16'h0, b[15:0]};
      OpLw:    return b;
      default: return 32'h0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [WORD_W-1:0] init_ptr_q, init_ptr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        lane_q, lane_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       hold_q, hold_d;
  logic              resp_valid_q, resp_valid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [WORD_W-1:0] mem_word;
  logic [3:0]        we;
  logic [7:0]        wbyte [4];
  logic [7:0]        rd_byte [4];

  logic [1:0]  cur_lane;
  logic [2:0]  cur_size;
  logic [31:0] st_src;
  logic [31:0] rot;
  logic [31:0] asm_word;
  logic [3:0]  beat1_mask;
  logic [3:0]  beat2_mask;
  logic [7:0]  st_byte [4];
  logic        crossing;

  // All four lanes share one word index per cycle: the sweep pointer, the request word, or
  // word+1 during the second beat.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];
    always_ff @(posedge clk) begin
      if (we[l]) begin
        mem_q[mem_word] <= wbyte[l];
      end
    end
    assign rd_byte[l] = mem_q[mem_word];
  end

  // Lane/byte mapping: byte k of the access lives in lane (lane+k) mod 4.
  always_comb begin
    cur_lane   = (state_q == StSplit) ? lane_q : addr[1:0];
    cur_size   = (state_q == StSplit) ? op_size(op_q) : op_size(op);
    st_src     = (state_q == StSplit) ? wdata_q : wdata;
    rot        = '0;
    asm_word   = '0;
    beat1_mask = '0;
    beat2_mask = '0;
    for (int l = 0; l < 4; l++) begin
      st_byte[l] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      rot[8*k +: 8] = rd_byte[2'(cur_lane + 2'(k))];
    end
    // Bytes that did not carry past lane 3 were captured on the first beat.
    for (int k = 0; k < 4; k++) begin
      asm_word[8*k +: 8] = ((4'(k) + 4'(lane_q)) < 4'd4) ? hold_q[8*k +: 8] : rot[8*k +: 8];
    end
    for (int l = 0; l < 4; l++) begin
      st_byte[l]    = 8'(st_src >> {2'(l) - cur_lane, 3'b000});
      beat1_mask[l] = (2'(l) >= cur_lane) && ({1'b0, 2'(l) - cur_lane} < cur_size);
      beat2_mask[l] = (4'(l) + 4'd4) < (4'(cur_lane) + 4'(cur_size));
    end
    crossing = (4'(cur_lane) + 4'(cur_size)) > 4'd4;
  end

  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    word_d       = word_q;
    lane_d       = lane_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    hold_d       = hold_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    req_ready    = 1'b0;
    mem_word     = addr[ADDR_W-1:2];
    we           = '0;
    for (int l = 0; l < 4; l++) begin
      wbyte[l] = st_byte[l];
    end

    unique case (state_q)
      StInit: begin
        if (INIT_ON_RESET) begin
          mem_word = init_ptr_q;
          we       = 4'hF;
          for (int l = 0; l < 4; l++) begin
            wbyte[l] = INIT_VALUE[8*l +: 8];
          end
          init_ptr_d = init_ptr_q + WORD_W'(1);
          if (init_ptr_q == WORD_W'(DEPTH_WORDS - 1)) begin
            state_d = StIdle;
          end
        end else begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if ((op_size(op) == 3'd0) || (crossing && !ALLOW_MISALIGN)) begin
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = 32'h0;
          end else begin
            if (op_is_store(op)) begin
              we = beat1_mask;
            end
            if (crossing) begin
              word_d  = addr[ADDR_W-1:2];
              lane_d  = addr[1:0];
              op_d    = op;
              wdata_d = wdata;
              hold_d  = rot;
              state_d = StSplit;
            end else begin
              resp_valid_d = 1'b1;
              rdata_d      = load_fmt(op, rot);
            end
          end
        end
      end

      StSplit: begin
        mem_word = word_q + WORD_W'(1);
        if (op_is_store(op_q)) begin
          we = beat2_mask;
        end
        resp_valid_d = 1'b1;
        rdata_d      = load_fmt(op_q, asm_word);
        state_d      = StIdle;
      end

      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StInit;
      init_ptr_q   <= '0;
      word_q       <= '0;
      lane_q       <= '0;
      op_q         <= '0;
      wdata_q      <= '0;
      hold_q       <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: three configurations share one stimulus stream, expected
// responses go through a scoreboard queue checked when resp_valid pulses.
module tb_dmem_lsu;

  localparam logic [5:0] LB  = 6'b010011;
  localparam logic [5:0] LH  = 6'b010100;
  localparam logic [5:0] LW  = 6'b010101;
  localparam logic [5:0] LBU = 6'b010110;
  localparam logic [5:0] LHU = 6'b010111;
  localparam logic [5:0] SB  = 6'b011000;
  localparam logic [5:0] SH  = 6'b011001;
  localparam logic [5:0] SW  = 6'b011010;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          cyc;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        va, vb, vc;
  logic [5:0]  t_op;
  logic [10:0] t_addr;
  logic [31:0] t_wdata;

  logic        ready_a, ready_b, ready_c;
  logic        rv_a, rv_b, rv_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        err_a, err_b, err_c;

  logic        ready_s, rv_s, err_s;
  logic [31:0] rd_s;

  int   sel = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu #(.ADDR_W(6), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h0), .ALLOW_MISALIGN(1'b1)) u_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(ready_a), .op(t_op), .addr(t_addr[5:0]),
    .wdata(t_wdata), .resp_valid(rv_a), .rdata(rd_a), .err(err_a)
  );

  dmem_lsu #(.ADDR_W(6), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h0), .ALLOW_MISALIGN(1'b0)) u_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(ready_b), .op(t_op), .addr(t_addr[5:0]),
    .wdata(t_wdata), .resp_valid(rv_b), .rdata(rd_b), .err(err_b)
  );

  dmem_lsu #(.ADDR_W(11), .INIT_ON_RESET(1'b0), .INIT_VALUE(32'h0), .ALLOW_MISALIGN(1'b1)) u_c (
    .clk(clk), .rst(rst), .req_valid(vc), .req_ready(ready_c), .op(t_op), .addr(t_addr),
    .wdata(t_wdata), .resp_valid(rv_c), .rdata(rd_c), .err(err_c)
  );

  always_comb begin
    ready_s = ready_a;
    rv_s    = rv_a;
    rd_s    = rd_a;
    err_s   = err_a;
    case (sel)
      1: begin ready_s = ready_b; rv_s = rv_b; rd_s = rd_b; err_s = err_b; end
      2: begin ready_s = ready_c; rv_s = rv_c; rd_s = rd_c; err_s = err_c; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_valid(input logic v);
    va = v && (sel == 0);
    vb = v && (sel == 1);
    vc = v && (sel == 2);
  endtask

  // Called at a falling edge; returns at the next falling edge with valid dropped.
  task automatic send(input logic [5:0] o, input logic [10:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input int lat, input string tag);
    int   n;
    exp_t ent;
    n = 0;
    set_valid(1'b0);
    while (!ready_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s) begin
      check({tag, "_ready_timeout"}, {31'b0, ready_s}, 32'd1);
      return;
    end
    t_op    = o;
    t_addr  = a;
    t_wdata = d;
    set_valid(1'b1);
    ent.rdata = er;
    ent.err   = ee;
    ent.lat   = lat;
    ent.cyc   = cyc;
    ent.tag   = tag;
    sb.push_back(ent);
    @(negedge clk);
    set_valid(1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst && rv_s) begin
      if (sb.size() == 0) begin
        check("spurious_resp", {31'b0, rv_s}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_rdata"}, rd_s, mon_e.rdata);
        check({mon_e.tag, "_err"}, {31'b0, err_s}, {31'b0, mon_e.err});
        check({mon_e.tag, "_lat"}, cyc - mon_e.cyc, mon_e.lat);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    t_op = '0; t_addr = '0; t_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready_a}, 32'd0);
    check("rst_resp_valid", {31'b0, rv_a}, 32'd0);
    check("rst_rdata", rd_a, 32'd0);
    check("rst_err", {31'b0, err_a}, 32'd0);

    rst = 1'b1;
    n = 0;
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("init_sweep_cycles", n, 32'd16);

    sel = 0;
    send(LW,  11'h03C, 32'h0,         32'h0000_0000, 1'b0, 1, "lw_after_init");
    send(SW,  11'h010, 32'h8899_AABB, 32'h0000_0000, 1'b0, 1, "sw_10");
    send(LB,  11'h010, 32'h0,         32'hFFFF_FFBB, 1'b0, 1, "lb_10");
    send(LBU, 11'h010, 32'h0,         32'h0000_00BB, 1'b0, 1, "lbu_10");
    send(LH,  11'h010, 32'h0,         32'hFFFF_AABB, 1'b0, 1, "lh_10");
    send(LHU, 11'h010, 32'h0,         32'h0000_AABB, 1'b0, 1, "lhu_10");
    send(LW,  11'h010, 32'h0,         32'h8899_AABB, 1'b0, 1, "lw_10");
    send(LB,  11'h012, 32'h0,         32'hFFFF_FF99, 1'b0, 1, "lb_12");
    send(SW,  11'h010, 32'h1122_3344, 32'h0000_0000, 1'b0, 1, "sw_10b");
    send(SB,  11'h012, 32'hAAAA_AA7F, 32'h0000_0000, 1'b0, 1, "sb_12");
    send(LW,  11'h010, 32'h0,         32'h117F_3344, 1'b0, 1, "lw_after_sb");
    send(LBU, 11'h013, 32'h0,         32'h0000_0011, 1'b0, 1, "lbu_13");

    send(SW,  11'h00E, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, "sw_split");
    check("split_bubble", {31'b0, ready_s}, 32'd0);
    @(negedge clk);
    check("split_ready_back", {31'b0, ready_s}, 32'd1);
    send(LW,  11'h00C, 32'h0,         32'hBEEF_0000, 1'b0, 1, "lw_0c");
    send(LW,  11'h010, 32'h0,         32'h117F_DEAD, 1'b0, 1, "lw_10_split");
    send(LH,  11'h00F, 32'h0,         32'hFFFF_ADBE, 1'b0, 2, "lh_0f_split");
    drain("a_split");
    @(negedge clk);
    check("hold_resp_low", {31'b0, rv_s}, 32'd0);
    check("hold_rdata", rd_s, 32'hFFFF_ADBE);
    send(6'b000000, 11'h010, 32'h0,   32'h0000_0000, 1'b1, 1, "illegal_op0");
    send(6'b111111, 11'h00E, 32'h0,   32'h0000_0000, 1'b1, 1, "illegal_op3f");
    drain("a_err");

    sel = 1;
    send(SW,  11'h00E, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1, "b_sw_reject");
    check("b_no_bubble", {31'b0, ready_s}, 32'd1);
    send(LW,  11'h00C, 32'h0,         32'h0000_0000, 1'b0, 1, "b_lw_0c");
    send(LW,  11'h010, 32'h0,         32'h0000_0000, 1'b0, 1, "b_lw_10");
    send(LH,  11'h00E, 32'h0,         32'h0000_0000, 1'b0, 1, "b_lh_0e");
    drain("b");

    sel = 2;
    send(SH,  11'h7FF, 32'h0000_CAFE, 32'h0000_0000, 1'b0, 2, "c_sh_wrap");
    send(LBU, 11'h7FF, 32'h0,         32'h0000_00FE, 1'b0, 1, "c_lbu_7ff");
    send(LBU, 11'h000, 32'h0,         32'h0000_00CA, 1'b0, 1, "c_lbu_000");
    send(LHU, 11'h7FF, 32'h0,         32'h0000_CAFE, 1'b0, 2, "c_lhu_wrap");
    drain("c_wrap");

    // Reset lands while the split store sits between its beats.
    send(SH,  11'h7FF, 32'h0000_1234, 32'h0000_0000, 1'b0, 2, "c_sh_abort");
    rst = 1'b0;
    #1;
    check("midop_resp_valid", {31'b0, rv_s}, 32'd0);
    check("midop_ready", {31'b0, ready_s}, 32'd0);
    check("midop_pending", sb.size(), 32'd1);
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    send(LBU, 11'h7FF, 32'h0,         32'h0000_0034, 1'b0, 1, "c_beat1_kept");
    send(LBU, 11'h000, 32'h0,         32'h0000_00CA, 1'b0, 1, "c_beat2_skipped");
    drain("c_abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
